id_decode_ctrl: RTL and testbench

//  Decode-stage controller that owns the IF/ID pipeline register and drives the immediate generator.
//  - Captures fetched instruction and PC over a valid/ready handshake.
//  - Decodes the opcode into the 3-bit immediate-type select.
//  - Inserts load-use bubbles.
//  - Presents the held instruction to EX over a second valid/ready handshake.

---
 rtl/id_decode_if.sv | 33 +++
 rtl/id_decode_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_id_decode_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_decode_if.sv
// id_decode_if: bundles the fetch-side and EX-side handshakes of the decode
// stage, plus the hazard inputs and the flush redirect.
//   master : the decode controller (drives in_ready, out_valid, id_*, imm_sel,
//            illegal_inst)
//   slave  : the surrounding pipeline (drives flush, in_valid, if_*, ex_*,
//            out_ready)
interface id_decode_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc;
    logic            ex_mem_read;
    logic [4:0]      ex_rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;
    logic [2:0]      imm_sel;
    logic            illegal_inst;

    modport master (
        input  flush, in_valid, if_inst, if_pc, ex_mem_read, ex_rd, out_ready,
        output in_ready, out_valid, id_inst, id_pc, imm_sel, illegal_inst
    );

    modport slave (
        output flush, in_valid, if_inst, if_pc, ex_mem_read, ex_rd, out_ready,
        input  in_ready, out_valid, id_inst, id_pc, imm_sel, illegal_inst
    );
endinterface

// File: rtl/id_decode_ctrl.sv
// id_decode_ctrl: decode-stage controller owning the IF/ID pipeline register.
// Captures instruction/PC from fetch, decodes the opcode into the immediate
// type select, inserts load-use bubbles and hands the held instruction to EX.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - id_decode_if.master (flush, fetch handshake, EX handshake,
//          ex_mem_read/ex_rd hazard inputs, id_inst/id_pc/imm_sel/illegal_inst)
//
// Parameters:
//   XLEN          width of PC and instruction words
//   STALL_CYCLES  bubble cycles spent in STALL per load-use hazard (1..7)
//
// Build option: define IMMSEL_ILLEGAL_DET_EN to register an illegal-opcode
// flag alongside id_inst; otherwise illegal_inst is constant 0.
//
// state | meaning
// EMPTY | nothing held, ready to capture from fetch
// FULL  | instruction held, offered to EX unless a load-use hazard is seen
// STALL | bubble countdown after a hazard, nothing offered or accepted
module id_decode_ctrl #(
    parameter int XLEN         = 32,
    parameter int STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    id_decode_if.master bus
);
    localparam logic [XLEN-1:0] NOP        = XLEN'(32'h0000_0013);
    localparam logic [2:0]      STALL_LOAD = 3'(STALL_CYCLES);

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    localparam logic [6:0] OP_R = 7'b0110011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      cnt, cnt_nx;
    logic [XLEN-1:0] inst_q, pc_q;
    logic [2:0]      imm_sel_q;
    logic            capture, clear;
    logic            in_ready, out_valid;
    logic            hazard, uses_rs1, uses_rs2;
    logic [4:0]      rs1, rs2;

    function automatic logic [2:0] decode_imm(input logic [6:0] op);
        logic [2:0] sel;
        sel = IMM_NONE;
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: sel = IMM_I;
            7'b0100011:                                     sel = IMM_S;
            7'b1100011:                                     sel = IMM_B;
            7'b0110111, 7'b0010111:                         sel = IMM_U;
            7'b1101111:                                     sel = IMM_J;
            default:                                        sel = IMM_NONE;
        endcase
        return sel;
    endfunction

    // Hazard is judged on the held word; imm_sel already tells us which
    // source fields are real, except R-type which shares the 000 code.
    assign rs1      = inst_q[19:15];
    assign rs2      = inst_q[24:20];
    assign uses_rs1 = (imm_sel_q != IMM_U) && (imm_sel_q != IMM_J);
    assign uses_rs2 = (inst_q[6:0] == OP_R) || (imm_sel_q == IMM_S) || (imm_sel_q == IMM_B);
    assign hazard   = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      (((bus.ex_rd == rs1) && uses_rs1) || ((bus.ex_rd == rs2) && uses_rs2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        clear     = 1'b0;
        case (state)
            EMPTY: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    capture  = 1'b1;
                    state_nx = FULL;
                end
            end
            FULL: begin
                if (hazard) begin
                    cnt_nx   = STALL_LOAD;
                    state_nx = STALL;
                end else begin
                    out_valid = 1'b1;
                    in_ready  = bus.out_ready;
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            capture = 1'b1;
                        end else begin
                            state_nx = EMPTY;
                        end
                    end
                end
            end
            STALL: begin
                // A zero count can only come from an out-of-range parameter;
                // treat it like the last bubble rather than wrapping.
                if (cnt <= 3'd1) begin
                    cnt_nx   = 3'd0;
                    state_nx = FULL;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            default: begin
                state_nx = EMPTY;
                cnt_nx   = 3'd0;
            end
        endcase
        // Redirect wins over everything: drop the incoming word and the held one.
        if (bus.flush) begin
            state_nx = EMPTY;
            cnt_nx   = 3'd0;
            in_ready = 1'b0;
            capture  = 1'b0;
            clear    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q    <= NOP;
            pc_q      <= '0;
            imm_sel_q <= IMM_NONE;
        end else if (clear) begin
            inst_q    <= NOP;
            imm_sel_q <= IMM_NONE;
        end else if (capture) begin
            inst_q    <= bus.if_inst;
            pc_q      <= bus.if_pc;
            imm_sel_q <= decode_imm(bus.if_inst[6:0]);
        end
    end

`ifdef IMMSEL_ILLEGAL_DET_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (clear) begin
            illegal_q <= 1'b0;
        end else if (capture) begin
            illegal_q <= (decode_imm(bus.if_inst[6:0]) == IMM_NONE) &&
                         (bus.if_inst[6:0] != OP_R);
        end
    end

    assign bus.illegal_inst = illegal_q;
`else
    assign bus.illegal_inst = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.id_inst   = inst_q;
    assign bus.id_pc     = pc_q;
    assign bus.imm_sel   = imm_sel_q;
endmodule

// File: tb/tb_id_decode_ctrl.sv
module tb_id_decode_ctrl;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADDI_X1  = 32'h0050_0093;
    localparam logic [31:0] ADDI_X4  = 32'h0010_0213;
    localparam logic [31:0] ADD_X3   = 32'h0020_81b3;
    localparam logic [31:0] SW_X1    = 32'h0011_2023;
    localparam logic [31:0] BEQ_X1   = 32'h0020_8063;
    localparam logic [31:0] LUI_X5   = 32'h0000_52b7;
    localparam logic [31:0] JAL_X0   = 32'h0000_006f;
    localparam int          N1       = 1;
    localparam int          N3       = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_decode_if #(.XLEN(32)) b1 ();
    id_decode_if #(.XLEN(32)) b3 ();

    id_decode_ctrl #(.XLEN(32), .STALL_CYCLES(N1)) dut  (.clk(clk), .rst(rst), .bus(b1));
    id_decode_ctrl #(.XLEN(32), .STALL_CYCLES(N3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    // ---------------- reference model (ISA-level rules) ----------------
    function automatic logic [2:0] ref_imm(input logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        if (op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011}) return 3'd1;
        if (op == 7'b0100011) return 3'd2;
        if (op == 7'b1100011) return 3'd3;
        if (op inside {7'b0110111, 7'b0010111}) return 3'd4;
        if (op == 7'b1101111) return 3'd5;
        return 3'd0;
    endfunction

    function automatic logic ref_illegal(input logic [31:0] i);
`ifdef IMMSEL_ILLEGAL_DET_EN
        return (ref_imm(i) == 3'd0) && (i[6:0] != 7'b0110011);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic ref_hazard(input logic [31:0] i, input logic mr, input logic [4:0] rd);
        logic [6:0] op;
        logic r1, r2;
        op = i[6:0];
        r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return mr && (rd != 5'd0) && (((rd == i[19:15]) && r1) || ((rd == i[24:20]) && r2));
    endfunction

    task automatic drive(input logic fl, input logic iv, input logic [31:0] inst,
                         input logic [31:0] pc, input logic mr, input logic [4:0] rd,
                         input logic ordy);
        b1.flush = fl; b1.in_valid = iv; b1.if_inst = inst; b1.if_pc = pc;
        b1.ex_mem_read = mr; b1.ex_rd = rd; b1.out_ready = ordy;
        b3.flush = fl; b3.in_valid = iv; b3.if_inst = inst; b3.if_pc = pc;
        b3.ex_mem_read = mr; b3.ex_rd = rd; b3.out_ready = ordy;
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, NOP, 32'h0, 1'b0, 5'd0, 1'b1);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", b1.out_valid); end
        checks++; if (b1.id_inst !== NOP) begin errors++; $display("FAIL reset_id_inst got %h exp %h", b1.id_inst, NOP); end
        checks++; if (b1.id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h exp 0", b1.id_pc); end
        checks++; if (b1.imm_sel !== 3'b000) begin errors++; $display("FAIL reset_imm_sel got %b exp 000", b1.imm_sel); end
        checks++; if (b1.illegal_inst !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", b1.illegal_inst); end
        checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", b1.in_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_capture();
        @(negedge clk);
        drive(1'b0, 1'b1, ADDI_X1, 32'h100, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready got %b exp 1", b1.in_ready); end
        checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL first_pre_valid got %b exp 0", b1.out_valid); end
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid got %b exp 1", b1.out_valid); end
        checks++; if (b1.imm_sel !== 3'b001) begin errors++; $display("FAIL first_imm_sel got %b exp 001", b1.imm_sel); end
        checks++; if (b1.id_pc !== 32'h100) begin errors++; $display("FAIL first_id_pc got %h exp 100", b1.id_pc); end
        checks++; if (b1.id_inst !== ADDI_X1) begin errors++; $display("FAIL first_id_inst got %h exp %h", b1.id_inst, ADDI_X1); end
        drain();
    endtask

    task automatic test_opcode_sweep();
        logic [31:0] tbl [6];
        tbl = '{SW_X1, BEQ_X1, LUI_X5, JAL_X0, ADD_X3, 32'h0000_0000};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, tbl[k], 32'h200 + 32'(k * 4), 1'b0, 5'd0, 1'b1);
            @(negedge clk);
            drive(1'b0, 1'b0, NOP, 32'h0, 1'b0, 5'd0, 1'b0);
            #1;
            checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid[%0d] got %b exp 1", k, b1.out_valid); end
            checks++; if (b1.imm_sel !== ref_imm(tbl[k])) begin errors++; $display("FAIL sweep_imm_sel[%0d] got %b exp %b", k, b1.imm_sel, ref_imm(tbl[k])); end
            checks++; if (b1.illegal_inst !== ref_illegal(tbl[k])) begin errors++; $display("FAIL sweep_illegal[%0d] got %b exp %b", k, b1.illegal_inst, ref_illegal(tbl[k])); end
        end
        drain();
    endtask

    task automatic test_load_use_stall();
        int cnt1, cnt3;
        bit seen1, seen3;
        cnt1 = 0; cnt3 = 0; seen1 = 0; seen3 = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, ADD_X3, 32'h300, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        // Load writing x2 sits in EX while add x3,x1,x2 is held.
        drive(1'b0, 1'b1, ADDI_X4, 32'h304, 1'b1, 5'd2, 1'b1);
        #1;
        checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL hazard_out_valid got %b exp 0", b1.out_valid); end
        checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL hazard_in_ready got %b exp 0", b1.in_ready); end
        // After the detection cycle the bubble has moved into EX.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, ADDI_X4, 32'h304, 1'b0, 5'd0, 1'b1);
            #1;
            if (!seen1) begin
                if (b1.out_valid === 1'b1) begin
                    seen1 = 1;
                    checks++; if (b1.id_inst !== ADD_X3) begin errors++; $display("FAIL stall1_inst got %h exp %h", b1.id_inst, ADD_X3); end
                end else begin
                    cnt1++;
                    checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL stall1_in_ready got %b exp 0", b1.in_ready); end
                end
            end
            if (!seen3) begin
                if (b3.out_valid === 1'b1) begin
                    seen3 = 1;
                    checks++; if (b3.id_inst !== ADD_X3) begin errors++; $display("FAIL stall3_inst got %h exp %h", b3.id_inst, ADD_X3); end
                end else begin
                    cnt3++;
                    checks++; if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL stall3_in_ready got %b exp 0", b3.in_ready); end
                end
            end
        end
        checks++; if (!seen1 || cnt1 != N1) begin errors++; $display("FAIL stall1_cycles got %0d (resumed %0b) exp %0d", cnt1, seen1, N1); end
        checks++; if (!seen3 || cnt3 != N3) begin errors++; $display("FAIL stall3_cycles got %0d (resumed %0b) exp %0d", cnt3, seen3, N3); end
        drain();
    endtask

    task automatic test_no_stall();
        @(negedge clk);
        drive(1'b0, 1'b1, LUI_X5, 32'h400, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, ADD_X3, 32'h404, 1'b1, 5'd5, 1'b0);
        #1;
        checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL lui_no_stall got %b exp 1", b1.out_valid); end
        checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL lui_in_ready got %b exp 0", b1.in_ready); end
        @(negedge clk);
        drive(1'b0, 1'b1, ADD_X3, 32'h404, 1'b1, 5'd5, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if (b1.out_valid !== 1'b1 || b1.id_inst !== ADD_X3) begin errors++; $display("FAIL rd0_no_stall got valid %b inst %h exp 1 %h", b1.out_valid, b1.id_inst, ADD_X3); end
        drain();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b0, 1'b1, SW_X1, 32'h500, 1'b0, 5'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, BEQ_X1, 32'h504, 1'b0, 5'd0, 1'b0);
            #1;
            checks++; if (b1.id_inst !== SW_X1 || b1.id_pc !== 32'h500 || b1.imm_sel !== 3'b010) begin errors++; $display("FAIL hold_stable[%0d] got %h/%h/%b exp %h/500/010", c, b1.id_inst, b1.id_pc, b1.imm_sel, SW_X1); end
            checks++; if (b1.in_ready !== 1'b0 || b1.out_valid !== 1'b1) begin errors++; $display("FAIL hold_handshake[%0d] got ir %b ov %b exp 0 1", c, b1.in_ready, b1.out_valid); end
        end
        @(negedge clk);
        drive(1'b0, 1'b1, BEQ_X1, 32'h504, 1'b0, 5'd0, 1'b1);
        #1;
        checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", b1.in_ready); end
        @(negedge clk);
        drive(1'b0, 1'b1, JAL_X0, 32'h508, 1'b0, 5'd0, 1'b1);
        #1;
        checks++; if (b1.id_inst !== BEQ_X1 || b1.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp %h/1", b1.id_inst, b1.out_valid, BEQ_X1); end
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (b1.id_inst !== JAL_X0 || b1.id_pc !== 32'h508) begin errors++; $display("FAIL b2b_second got %h/%h exp %h/508", b1.id_inst, b1.id_pc, JAL_X0); end
        drain();
    endtask

    task automatic test_flush();
        // flush while dut3 sits in STALL
        @(negedge clk);
        drive(1'b0, 1'b1, ADD_X3, 32'h600, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b1, 5'd2, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, ADDI_X4, 32'h604, 1'b0, 5'd0, 1'b1);
        #1;
        checks++; if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL flush_stall_in_ready got %b exp 0", b3.in_ready); end
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b0, 5'd0, 1'b1);
        #1;
        checks++; if (b3.out_valid !== 1'b0 || b3.id_inst !== NOP || b3.imm_sel !== 3'b000) begin errors++; $display("FAIL flush_stall_state got %b/%h/%b exp 0/%h/000", b3.out_valid, b3.id_inst, b3.imm_sel, NOP); end
        @(negedge clk);
        #1;
        checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_dropped got %b exp 0", b3.out_valid); end
        // flush while FULL with a word arriving
        @(negedge clk);
        drive(1'b0, 1'b1, ADDI_X1, 32'h700, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, SW_X1, 32'h704, 1'b0, 5'd0, 1'b1);
        #1;
        checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_in_ready got %b exp 0", b1.in_ready); end
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b0, 5'd0, 1'b1);
        #1;
        checks++; if (b1.out_valid !== 1'b0 || b1.id_inst !== NOP || b1.imm_sel !== 3'b000) begin errors++; $display("FAIL flush_full_state got %b/%h/%b exp 0/%h/000", b1.out_valid, b1.id_inst, b1.imm_sel, NOP); end
        @(negedge clk);
        #1;
        checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_dropped got %b exp 0", b1.out_valid); end
        drain();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, ADD_X3, 32'h800, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b1, 5'd2, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b0, 5'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (b3.out_valid !== 1'b0 || b3.id_inst !== NOP || b3.id_pc !== 32'h0 || b3.imm_sel !== 3'b000) begin errors++; $display("FAIL async_rst got %b/%h/%h/%b exp 0/%h/0/000", b3.out_valid, b3.id_inst, b3.id_pc, b3.imm_sel, NOP); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, ADDI_X1, 32'h900, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (b3.out_valid !== 1'b1 || b3.id_pc !== 32'h900) begin errors++; $display("FAIL rst_no_bubble got %b/%h exp 1/900", b3.out_valid, b3.id_pc); end
        drain();
    endtask

    task automatic test_random();
        logic [6:0]  ops [12];
        bit          present;
        logic [31:0] held, held_pc;
        int          stall_left;
        logic        fl, iv, mr, ordy, hz, exp_ov, exp_ir;
        logic [4:0]  rd;
        logic [31:0] inst, pc;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0000000, 7'b0001111};
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        present = 0; held = NOP; held_pc = 32'h0; stall_left = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            fl   = ($urandom_range(0, 15) == 0);
            iv   = $urandom_range(0, 1);
            mr   = ($urandom_range(0, 2) == 0);
            rd   = 5'($urandom_range(0, 3));
            ordy = ($urandom_range(0, 3) != 0);
            inst = $urandom;
            inst[6:0]   = ops[$urandom_range(0, 11)];
            inst[19:15] = 5'($urandom_range(0, 3));
            inst[24:20] = 5'($urandom_range(0, 3));
            pc   = 32'($urandom) & 32'hffff_fffc;
            drive(fl, iv, inst, pc, mr, rd, ordy);
            #1;
            hz     = present && (stall_left == 0) && ref_hazard(held, mr, rd);
            exp_ov = present && (stall_left == 0) && !hz;
            exp_ir = !fl && (!present || (exp_ov && ordy));
            checks++; if (b1.out_valid !== exp_ov) begin errors++; $display("FAIL rnd_out_valid[%0d] got %b exp %b", c, b1.out_valid, exp_ov); end
            checks++; if (b1.in_ready !== exp_ir) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", c, b1.in_ready, exp_ir); end
            if (exp_ov) begin
                checks++; if (b1.id_inst !== held || b1.id_pc !== held_pc) begin errors++; $display("FAIL rnd_held[%0d] got %h/%h exp %h/%h", c, b1.id_inst, b1.id_pc, held, held_pc); end
                checks++; if (b1.imm_sel !== ref_imm(held) || b1.illegal_inst !== ref_illegal(held)) begin errors++; $display("FAIL rnd_decode[%0d] got %b/%b exp %b/%b", c, b1.imm_sel, b1.illegal_inst, ref_imm(held), ref_illegal(held)); end
            end
            @(posedge clk);
            if (fl) begin
                present = 0; held = NOP; stall_left = 0;
            end else if (stall_left > 0) begin
                stall_left--;
            end else if (hz) begin
                stall_left = N1;
            end else if (iv && exp_ir) begin
                present = 1; held = inst; held_pc = pc;
            end else if (exp_ov && ordy) begin
                present = 0;
            end
        end
        drain();
    endtask

    initial begin
        drive(1'b0, 1'b0, NOP, 32'h0, 1'b0, 5'd0, 1'b0);
        test_reset();
        test_first_capture();
        test_opcode_sweep();
        test_load_use_stall();
        test_no_stall();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
